systolic_feed_ctrl: RTL

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

---
 rtl/systolic_feed_ctrl_pkg.sv | 17 +
 rtl/systolic_feed_ctrl_feed_skew_window.sv | 26 ++
 rtl/systolic_feed_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared FSM encoding and counter sizing for the systolic array feed controller.
package systolic_feed_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FEED = 2'd2,
    FIN  = 2'd3
  } fsm_state_t;

  // The feed counter must hold ROWS+LEN-2 without wrapping, so it gets one bit
  // more than the wider of the row index and the FIFO pointer.
  function automatic int cnt_width(input int rows_log2, input int depth_log2);
    return ((rows_log2 > depth_log2) ? rows_log2 : depth_log2) + 1;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_feed_skew_window.sv
// Skewed diagonal pop window: row i is popped while i <= t < i+len, unless held.
module feed_skew_window
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int ROWS       = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int CW         = 6
) (
  input  logic                  en,
  input  logic                  hold,
  input  logic [CW-1:0]         t,
  input  logic [DEPTH_LOG2-1:0] len,
  output logic [ROWS-1:0]       pope
);

  logic [CW-1:0] len_w;
  assign len_w = CW'(len);

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    logic lo_ok, hi_ok;
    assign lo_ok   = (t >= CW'(i));
    assign hi_ok   = (t < (CW'(i) + len_w));
    assign pope[i] = en & ~hold & lo_ok & hi_ok;
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Row-FIFO feed controller for a systolic PE array: load a tile, then pop it out
// on a skewed diagonal. Optional underflow check: define FEED_UNDERFLOW_CHK_EN.
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int ROWS       = 32,
  parameter int ROWS_LOG2  = 5,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DEPTH_LOG2-1:0] LEN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  HOLD,
  input  logic [ROWS-1:0]       FIFO_EMPTY,
  output logic [ROWS-1:0]       PUSHE,
  output logic [ROWS-1:0]       POPE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int CW = cnt_width(ROWS_LOG2, DEPTH_LOG2);

  fsm_state_t            state;
  logic [DEPTH_LOG2-1:0] len_q;
  logic [DEPTH_LOG2-1:0] load_cnt;
  logic [DEPTH_LOG2-1:0] load_nxt;
  logic [CW-1:0]         t;
  logic [CW-1:0]         feed_last;
  logic                  start_ok;
  logic                  in_load;
  logic                  in_feed;

  // A tile may only start onto fully drained FIFOs.
  assign start_ok  = (state == IDLE) & START & (LEN != '0) & (&FIFO_EMPTY);
  assign in_load   = (state == LOAD);
  assign in_feed   = (state == FEED);
  assign load_nxt  = load_cnt + 1'b1;
  assign feed_last = CW'(ROWS) + CW'(len_q) - CW'(2);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      len_q    <= '0;
      load_cnt <= '0;
      t        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q    <= LEN;
            load_cnt <= '0;
            t        <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (IN_VALID) begin
            load_cnt <= load_nxt;
            if (load_nxt == len_q) state <= FEED;
          end
        end
        FEED: begin
          if (!HOLD) begin
            if (t == feed_last) state <= FIN;
            else                t     <= t + 1'b1;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign IN_READY = in_load;
  assign PUSHE    = {ROWS{in_load & IN_VALID}};
  assign BUSY     = (state != IDLE);
  assign DONE     = (state == FIN);

  feed_skew_window #(
    .ROWS       (ROWS),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CW         (CW)
  ) u_skew (
    .en   (in_feed),
    .hold (HOLD),
    .t    (t),
    .len  (len_q),
    .pope (POPE)
  );

`ifdef FEED_UNDERFLOW_CHK_EN
  logic err_q;

  // Sticky until the next tile is accepted, so software can read it after DONE.
  always_ff @(posedge CLK) begin
    if (RST)                      err_q <= 1'b0;
    else if (start_ok)            err_q <= 1'b0;
    else if (|(POPE & FIFO_EMPTY)) err_q <= 1'b1;
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule
